// File: rtl/bus_driver.sv
// rtl/bus_driver.sv - tri-state bus driver with registered monitor; BUS_DRIVER_STATS_EN adds saturating counters
module bus_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_en,
  output tri   [DATA_WIDTH-1:0] data_out,
  output logic                  driving,
  output logic                  en_rise,
  output logic [DATA_WIDTH-1:0] last_driven,
  output logic [CNT_WIDTH-1:0]  drive_cycles,
  output logic [CNT_WIDTH-1:0]  en_edges
);

  logic oe;
  logic oe_rise;

  // Reset gates the enable so the bus releases without waiting for a clock.
  assign oe       = data_en & rst_n;
  assign oe_rise  = oe & ~driving;
  assign data_out = oe ? data_in : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      driving     <= 1'b0;
      en_rise     <= 1'b0;
      last_driven <= '0;
    end else begin
      driving <= oe;
      en_rise <= oe_rise;
      if (oe) begin
        last_driven <= data_in;
      end
    end
  end

`ifdef BUS_DRIVER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drive_cycles <= '0;
      en_edges     <= '0;
    end else begin
      if (oe && (drive_cycles != {CNT_WIDTH{1'b1}})) begin
        drive_cycles <= drive_cycles + CNT_WIDTH'(1);
      end
      if (oe_rise && (en_edges != {CNT_WIDTH{1'b1}})) begin
        en_edges <= en_edges + CNT_WIDTH'(1);
      end
    end
  end
`else
  assign drive_cycles = '0;
  assign en_edges     = '0;
`endif

endmodule

// File: tb/tb_bus_driver.sv
// tb/tb_bus_driver.sv - scoreboard bench for bus_driver (counters checked per BUS_DRIVER_STATS_EN)
module tb_bus_driver;

  localparam int DW = 8;
  localparam int CW = 2;
`ifdef BUS_DRIVER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          data_en;
  tri   [DW-1:0] data_out;
  logic          driving;
  logic          en_rise;
  logic [DW-1:0] last_driven;
  logic [CW-1:0] drive_cycles;
  logic [CW-1:0] en_edges;
  logic          bus_float;

  bus_driver #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_en(data_en),
    .data_out(data_out), .driving(driving), .en_rise(en_rise),
    .last_driven(last_driven), .drive_cycles(drive_cycles), .en_edges(en_edges)
  );

  assign bus_float = (data_out === {DW{1'bz}});

  always #5 clk = ~clk;

  typedef struct packed {
    logic          driving;
    logic          en_rise;
    logic [DW-1:0] last;
    logic [CW-1:0] dc;
    logic [CW-1:0] ee;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic          m_driving = 1'b0;
  logic [DW-1:0] m_last    = '0;
  logic [CW-1:0] m_dc      = '0;
  logic [CW-1:0] m_ee      = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_driving = 1'b0;
    m_last    = '0;
    m_dc      = '0;
    m_ee      = '0;
    sb.delete();
  endtask

  // Drive one cycle of stimulus, check the combinational bus, then score the monitor after the edge.
  task automatic step(input logic [DW-1:0] din, input logic en);
    exp_t e;
    exp_t got;
    logic rise;
    data_in = din;
    data_en = en;
    #1;
    if (en) begin
      check("bus_value", data_out, din);
      check("bus_driven", bus_float, 1'b0);
    end else begin
      check("bus_float", bus_float, 1'b1);
    end
    rise = en & ~m_driving;
    m_driving = en;
    if (en) m_last = din;
    if (STATS) begin
      if (en && m_dc != '1) m_dc = m_dc + 1'b1;
      if (rise && m_ee != '1) m_ee = m_ee + 1'b1;
    end
    e = '{driving: en, en_rise: rise, last: m_last, dc: m_dc, ee: m_ee};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 1'b1, 1'b0);
    end else begin
      got = sb.pop_front();
      check("driving", driving, got.driving);
      check("en_rise", en_rise, got.en_rise);
      check("last_driven", last_driven, got.last);
      check("drive_cycles", drive_cycles, got.dc);
      check("en_edges", en_edges, got.ee);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    data_in = 8'h00;
    data_en = 1'b1;
    #12;
    check("rst_bus_float", bus_float, 1'b1);
    check("rst_driving", driving, 1'b0);
    check("rst_en_rise", en_rise, 1'b0);
    check("rst_last", last_driven, 0);
    check("rst_dc", drive_cycles, 0);
    check("rst_ee", en_edges, 0);
    data_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step(8'h55, 1'b1);
    step(8'h55, 1'b0);
    step(8'h11, 1'b1);
    step(8'h22, 1'b1);
    step(8'h33, 1'b1);
    step(8'hFF, 1'b0);
    step(8'hFF, 1'b0);
    check("hold_last", last_driven, 8'h33);

    // Enable pulse between edges must not register.
    data_en = 1'b1;
    data_in = 8'h5A;
    #1;
    check("glitch_bus", data_out, 8'h5A);
    step(8'h5A, 1'b0);

    step(8'hA3, 1'b1);
    data_in = 8'hA3;
    data_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_float", bus_float, 1'b1);
    check("mid_rst_driving", driving, 1'b0);
    check("mid_rst_en_rise", en_rise, 1'b0);
    check("mid_rst_last", last_driven, 0);
    check("mid_rst_dc", drive_cycles, 0);
    check("mid_rst_ee", en_edges, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 5; i++) step(8'h40 + 8'(i), 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 1'b0);
      step(8'h90 + 8'(i), 1'b1);
    end
    step(8'h00, 1'b0);

    for (int i = 0; i < 40; i++) step(8'($urandom), 1'($urandom_range(0, 1)));

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
